pb_debounce: RTL and testbench

Debounces and synchronises one raw mechanical push-button input. It produces a clean, glitch-free level for the one-cycle press-pulse edge detector directly downstream. The block combines a two-flop synchroniser with a counter-qualified four-state FSM. It also keeps a saturating count of rejected bounces for board bring-up diagnostics.

---
 rtl/pb_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/pb_debounce.sv | 100 ++++++++++
 tb/tb_pb_debounce.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default qualification length and the diagnostic bounce counter helpers.
package pb_pkg;

  // The four states form a Gray sequence (00 -> 01 -> 11 -> 10 -> 00).
  // Every legal transition flips exactly one bit.
  // state[1] is the debounced level and state[1]^state[0] is busy.
  typedef enum logic [1:0] {
    S_LOW     = 2'b00,
    S_WAIT_HI = 2'b01,
    S_HIGH    = 2'b11,
    S_WAIT_LO = 2'b10
  } pb_state_e;

  // 10 ms of stability at a 100 MHz system clock.
  localparam int unsigned PB_DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  // Width and ceiling of the rejected-bounce diagnostic counter.
  localparam int unsigned          PB_BOUNCE_W   = 8;
  localparam logic [PB_BOUNCE_W-1:0] PB_BOUNCE_MAX = '1;

  // Saturating increment: sticks at the ceiling instead of wrapping.
  function automatic logic [PB_BOUNCE_W-1:0] pb_sat_inc(input logic [PB_BOUNCE_W-1:0] v);
    return (v == PB_BOUNCE_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous board input.
// Both stages clear to 0 on reset, so an input sampled during reset looks like "inactive".
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  // Next-state for the shift chain.
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // The metastability-settling chain is cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pb_debounce.sv
// Push-button debouncer. The raw input is synchronised first.
// A candidate level change is then qualified by DEBOUNCE_CYCLES consecutive stable samples before the output moves.
// Aborted qualifications are counted, saturating, for bring-up diagnostics.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pb_in,
  output logic                   pb_out,
  output logic                   busy,
  output logic [PB_BOUNCE_W-1:0] bounce_cnt
);

  // Terminal count: the last counter value before the level is accepted.
  // The compare uses the full CNT_W bits, so DEBOUNCE_CYCLES up to 2^CNT_W fits.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   pb_sync;
  pb_state_e              state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic [PB_BOUNCE_W-1:0] bounce_d, bounce_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pb_in),
    .q   (pb_sync)
  );

  // Next-state, stability counter and bounce counter.
  // All defaults hold, and the stable states keep cnt parked at 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bounce_d = bounce_q;
    unique case (state_q)
      S_LOW: begin
        cnt_d = '0;
        if (pb_sync) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (!pb_sync) begin
          state_d  = S_LOW;
          cnt_d    = '0;
          bounce_d = pb_sat_inc(bounce_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        cnt_d = '0;
        if (!pb_sync) state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (pb_sync) begin
          state_d  = S_HIGH;
          cnt_d    = '0;
          bounce_d = pb_sat_inc(bounce_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and diagnostics registers.
  // Reset drops straight to S_LOW, so the output can only fall (or stay low) at assertion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_LOW;
      cnt_q    <= '0;
      bounce_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bounce_q <= bounce_d;
    end
  end

  // Outputs are single bits of the Gray-coded state register.
  // pb_out therefore has no combinational path from pb_in and cannot glitch.
  assign pb_out     = state_q[1];
  assign busy       = state_q[1] ^ state_q[0];
  assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_pb_debounce.sv
// Self-checking bench for pb_debounce (DEBOUNCE_CYCLES=4, CNT_W=3).
// The reference model tracks, for each sampled synchronised level, how long it has disagreed with the accepted output.
module tb_pb_debounce;

  localparam int D  = 4;
  localparam int CW = 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       pb_in = 1'b0;
  logic       pb_out;
  logic       busy;
  logic [7:0] bounce_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: two-sample delay line, accepted level, disagreement run length, bounce count.
  int m_s1, m_s2, m_out, m_run, m_bounce;
  int prev_out, rise_cnt;

  pb_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pb_in      (pb_in),
    .pb_out     (pb_out),
    .busy       (busy),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_out = 0; m_run = 0; m_bounce = 0;
    prev_out = 0;
  endtask

  // A level differing from the output must be seen D+1 times in a row to be accepted.
  // A shorter run that ends is a rejected bounce.
  task automatic model_edge();
    int ps;
    ps   = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(pb_in);
    if (ps != m_out) begin
      m_run++;
      if (m_run == D + 1) begin
        m_out = ps;
        m_run = 0;
      end
    end else if (m_run > 0) begin
      if (m_bounce < 255) m_bounce++;
      m_run = 0;
    end
  endtask

  // Drive one input value for one clock, advance the model and compare all outputs just after the edge.
  task automatic apply_stimulus(input logic val);
    pb_in = val;
    @(posedge clk);
    model_edge();
    #1;
    check_output("pb_out", int'(pb_out), m_out);
    check_output("busy", int'(busy), (m_run > 0) ? 1 : 0);
    check_output("bounce_cnt", int'(bounce_cnt), m_bounce);
    if (pb_out && prev_out == 0) rise_cnt++;
    prev_out = int'(pb_out);
  endtask

  // Asynchronous reset pulse taken between clock edges.
  // Outputs must clear at once, without waiting for a clock.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_output("rst_pb_out", int'(pb_out), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_bounce", int'(bounce_cnt), 0);
    model_reset();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int first;
    int reached;
    model_reset();
    rise_cnt = 0;
    #1;
    check_output("init_pb_out", int'(pb_out), 0);
    check_output("init_busy", int'(busy), 0);
    check_output("init_bounce", int'(bounce_cnt), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Clean press: busy after edge 2, pb_out after edge 6.
    first = -1;
    reached = -1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1);
      if (busy && reached < 0) reached = i;
      if (pb_out && first < 0) first = i;
    end
    check_output("press_busy_latency", reached, 2);
    check_output("press_latency", first, 6);
    check_output("press_bounce", int'(bounce_cnt), 0);

    // Three-cycle dip while high is rejected; then a real release.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1);
    check_output("dip_pb_out", int'(pb_out), 1);
    check_output("dip_bounce", int'(bounce_cnt), 1);
    first = -1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0);
      if (!pb_out && first < 0) first = i;
    end
    check_output("release_latency", first, 6);

    // Two-cycle glitch.
    for (int i = 0; i < 2; i++) apply_stimulus(1'b1);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0);
    check_output("glitch_bounce", int'(bounce_cnt), 2);

    // Chatter: three single-cycle pulses two cycles apart, then steady high.
    rise_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      apply_stimulus(1'b1);
      apply_stimulus(1'b0);
      apply_stimulus(1'b0);
    end
    first = -1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1);
      if (pb_out && first < 0) first = i;
    end
    check_output("chatter_bounce", int'(bounce_cnt), 5);
    check_output("chatter_latency", first, 6);
    check_output("chatter_rises", rise_cnt, 1);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b0);

    // Reset while qualifying a press with cnt=2 (third busy cycle), then requalify.
    reached = 0;
    for (int i = 0; i < 10 && reached == 0; i++) begin
      apply_stimulus(1'b1);
      if (m_run == 3) reached = 1;
    end
    check_output("rst_wait_reached", reached, 1);
    do_reset();
    rise_cnt = 0;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b1);
      if (pb_out && first < 0) first = i;
    end
    check_output("rst_release_latency", first, 6);
    check_output("rst_release_rises", rise_cnt, 1);

    // Randomised segments with occasional asynchronous resets.
    for (int s = 0; s < 400; s++) begin
      logic v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * D + 2);
      for (int i = 0; i < len; i++) apply_stimulus(v);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    // Saturation: 300 single-cycle glitches from a clean low state.
    do_reset();
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0);
    for (int g = 0; g < 300; g++) begin
      apply_stimulus(1'b1);
      apply_stimulus(1'b0);
    end
    check_output("sat_bounce", int'(bounce_cnt), 255);
    check_output("sat_pb_out", int'(pb_out), 0);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1);
    check_output("sat_hold_bounce", int'(bounce_cnt), 255);
    check_output("sat_press_pb_out", int'(pb_out), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog to guarantee termination.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
